// File: rtl/riscv_fetch_pkg.sv
// riscv_fetch_pkg: shared state type and constants for the instruction fetch front end
package riscv_fetch_pkg;
    typedef enum logic [1:0] {BOOT, FETCH, HALTED} fetch_state_e;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_INC    = 32'd4;
endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: shift-register instruction queue with registered head outputs
module fetch_buffer
    import riscv_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [31:0]                push_pc_i,
    input  logic [31:0]                push_instr_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       valid_o,
    output logic [31:0]                pc_o,
    output logic [31:0]                instr_o
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [CW-1:0] count_q, count_d, base;
    logic          valid_q;
    logic [31:0]   pc_q, instr_q;

    always_comb begin
        base    = count_q - CW'(pop_i);
        count_d = flush_i ? '0 : base + CW'(push_i);
        for (int i = 0; i < DEPTH - 1; i++) mem_d[i] = pop_i ? mem_q[i+1] : mem_q[i];
        mem_d[DEPTH-1] = mem_q[DEPTH-1];
        if (push_i && !flush_i) mem_d[base[AW-1:0]] = '{pc: push_pc_i, instr: push_instr_i};
    end

    always_ff @(posedge clk_i) mem_q <= mem_d;

    // Head is re-registered from the next-state queue so the outputs are flops; empty holds the last head.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= NOP_INSTR;
        end else begin
            count_q <= count_d;
            valid_q <= count_d != '0;
            if (count_d != '0) begin
                pc_q    <= mem_d[0].pc;
                instr_q <= mem_d[0].instr;
            end
        end
    end

    assign count_o = count_q;
    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC sequencing, request throttling, redirect/halt control over a fetch_buffer
module fetch_sequencer
    import riscv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2,
    parameter int          ADDR_W   = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [31:0]       mem_rdata_i,
    input  logic              redirect_i,
    input  logic [31:0]       redirect_pc_i,
    input  logic              halt_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [31:0]       out_instr_o,
    output logic [31:0]       out_pc_o,
    output logic              busy_o
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = CW + 1;
    fetch_state_e  state_q;
    logic [31:0]   pc_q, inflight_pc_q;
    logic          inflight_q, redirect_act, pop, push;
    logic [CW-1:0] occ;

    // Counting the in-flight word against capacity is what keeps the buffer from overflowing.
    assign redirect_act = redirect_i && state_q != BOOT;
    assign mem_req_o    = state_q == FETCH && !redirect_i && PW'(occ) + PW'(inflight_q) < PW'(DEPTH);
    assign mem_addr_o   = pc_q[ADDR_W+1:2];
    assign pop          = out_valid_o && out_ready_i;
    assign push         = inflight_q && !redirect_act;
    assign busy_o       = inflight_q || occ != '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            inflight_q <= mem_req_o;
            if (mem_req_o) inflight_pc_q <= pc_q;
            if (redirect_act) pc_q <= redirect_pc_i & ~32'h3;
            else if (mem_req_o) pc_q <= pc_q + PC_INC;
            state_q <= state_q == BOOT ? FETCH : (halt_i ? HALTED : FETCH);
        end
    end

    fetch_buffer #(.DEPTH(DEPTH)) u_buf (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .push_i       (push),
        .push_pc_i    (inflight_pc_q),
        .push_instr_i (mem_rdata_i),
        .pop_i        (pop),
        .flush_i      (redirect_act),
        .count_o      (occ),
        .valid_o      (out_valid_o),
        .pc_o         (out_pc_o),
        .instr_o      (out_instr_o)
    );
endmodule
